// File: rtl/freq_drive_gen.sv
// freq_drive_gen: step-driven frequency word plus dead-time-protected complementary gate drive.
// Define FREQ_STEP_ADAPT_EN to halve the step on every change of step direction.
module freq_drive_gen #(
  parameter logic [19:0] F_INIT    = 20'd429497,
  parameter logic [19:0] F_MIN     = 20'd322123,
  parameter logic [19:0] F_MAX     = 20'd644245,
  parameter logic [19:0] STEP_INIT = 20'd1074,
  parameter logic [19:0] STEP_MIN  = 20'd67,
  parameter int          DEAD      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swiptAlive,
  input  logic        data_start,
  input  logic        freq_ready,
  input  logic        freq_set_up_down,
  input  logic        freq_opt,
  output logic [19:0] freq,
  output logic        step_ack,
  output logic        freq_sat,
  output logic        drv_p,
  output logic        drv_n
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] P_ON    = 3'd1;
  localparam logic [2:0] DEAD_PN = 3'd2;
  localparam logic [2:0] N_ON    = 3'd3;
  localparam logic [2:0] DEAD_NP = 3'd4;
  localparam logic [15:0] CNT_LOAD = 16'(DEAD - 1);

  if (DEAD < 1 || DEAD > 65535 || STEP_MIN > STEP_INIT || F_MIN > F_MAX) begin : g_bad_cfg
    $error("freq_drive_gen: inconsistent parameters");
  end

  logic        apply;
  logic [19:0] step_eff;
  logic [20:0] sum;
  logic [20:0] lo;
  logic        up_sat;
  logic        dn_sat;
  logic [19:0] freq_nx;

  assign apply = freq_ready && !freq_opt;

`ifdef FREQ_STEP_ADAPT_EN
  logic [19:0] step;
  logic [19:0] half;
  logic        prev_valid;
  logic        prev_dir;
  assign half     = step >> 1;
  assign step_eff = (prev_valid && prev_dir != freq_set_up_down) ? ((half < STEP_MIN) ? STEP_MIN : half) : step;
  always_ff @(posedge clk) begin
    if (rst || data_start) begin
      step       <= STEP_INIT;
      prev_valid <= 1'b0;
      prev_dir   <= 1'b0;
    end else if (apply) begin
      step       <= step_eff;
      prev_valid <= 1'b1;
      prev_dir   <= freq_set_up_down;
    end
  end
`else
  assign step_eff = STEP_INIT;
`endif

  // 21-bit arithmetic so the bound comparisons cannot wrap
  assign sum     = {1'b0, freq} + {1'b0, step_eff};
  assign lo      = {1'b0, F_MIN} + {1'b0, step_eff};
  assign up_sat  = sum > {1'b0, F_MAX};
  assign dn_sat  = {1'b0, freq} < lo;
  assign freq_nx = freq_set_up_down ? (up_sat ? F_MAX : sum[19:0]) : (dn_sat ? F_MIN : freq - step_eff);

  always_ff @(posedge clk) begin
    if (rst || data_start) begin
      freq     <= F_INIT;
      freq_sat <= 1'b0;
      step_ack <= 1'b0;
    end else begin
      step_ack <= apply;
      if (apply) begin
        freq     <= freq_nx;
        freq_sat <= freq_set_up_down ? up_sat : dn_sat;
      end
    end
  end

  logic [29:0] acc;
  logic [19:0] inc;
  logic [30:0] acc_sum;
  logic        raw;

  assign acc_sum = {1'b0, acc} + {11'b0, inc};

  // inc only follows freq at the wrap, so every output period is whole
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      inc <= F_INIT;
      raw <= 1'b0;
    end else begin
      raw <= acc[29];
      if (!swiptAlive) begin
        acc <= '0;
        inc <= freq;
      end else begin
        acc <= acc_sum[29:0];
        if (acc_sum[30]) inc <= freq;
      end
    end
  end

  logic [2:0]  state;
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !swiptAlive) begin
      state <= IDLE;
      cnt   <= '0;
      drv_p <= 1'b0;
      drv_n <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= DEAD_NP;
          cnt   <= CNT_LOAD;
        end
        P_ON: if (!raw) begin
          state <= DEAD_PN;
          drv_p <= 1'b0;
          cnt   <= CNT_LOAD;
        end
        N_ON: if (raw) begin
          state <= DEAD_NP;
          drv_n <= 1'b0;
          cnt   <= CNT_LOAD;
        end
        DEAD_PN, DEAD_NP: if (cnt == '0) begin
          state <= raw ? P_ON : N_ON;
          drv_p <= raw;
          drv_n <= !raw;
        end else begin
          cnt <= cnt - 16'd1;
        end
        default: begin
          state <= IDLE;
          drv_p <= 1'b0;
          drv_n <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_freq_drive_gen.sv
// tb_freq_drive_gen: directed checks of stepping, saturation, restart and gate timing.
module tb_freq_drive_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        swiptAlive = 1'b0;
  logic        data_start = 1'b0;
  logic        freq_ready = 1'b0;
  logic        freq_set_up_down = 1'b0;
  logic        freq_opt = 1'b0;
  logic [19:0] freq;
  logic        step_ack;
  logic        freq_sat;
  logic        drv_p;
  logic        drv_n;
  int checks = 0;
  int errors = 0;
  int overlaps = 0;

  freq_drive_gen dut (
    .clk(clk), .rst(rst), .swiptAlive(swiptAlive), .data_start(data_start),
    .freq_ready(freq_ready), .freq_set_up_down(freq_set_up_down), .freq_opt(freq_opt),
    .freq(freq), .step_ack(step_ack), .freq_sat(freq_sat), .drv_p(drv_p), .drv_n(drv_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (drv_p && drv_n) overlaps++;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    swiptAlive = 1'b0;
    data_start = 1'b0;
    freq_ready = 1'b0;
    freq_opt = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse(input logic up, input logic opt);
    freq_set_up_down = up;
    freq_opt = opt;
    freq_ready = 1'b1;
    @(negedge clk);
    freq_ready = 1'b0;
    freq_opt = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (freq !== 20'd429497) begin errors++; $display("FAIL reset_freq got %0d want 429497", freq); end
    if (drv_p !== 1'b0) begin errors++; $display("FAIL reset_drv_p got %b want 0", drv_p); end
    if (drv_n !== 1'b0) begin errors++; $display("FAIL reset_drv_n got %b want 0", drv_n); end
    if (step_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", step_ack); end
    if (freq_sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b want 0", freq_sat); end
    rst = 1'b0;
  endtask

  task automatic test_drive();
    int r1 = -1, r2 = -1, pf = -1, nr = -1;
    logic pp = 1'b0, pn = 1'b0;
    do_reset();
    swiptAlive = 1'b1;
    for (int c = 0; c < 8000 && r2 < 0; c++) begin
      @(negedge clk);
      if (drv_p && !pp) begin if (r1 < 0) r1 = c; else r2 = c; end
      if (!drv_p && pp && pf < 0) pf = c;
      if (drv_n && !pn && pf >= 0 && nr < 0) nr = c;
      pp = drv_p;
      pn = drv_n;
    end
    checks += 4;
    if (r1 < 0 || r2 < 0 || r2 - r1 < 2499 || r2 - r1 > 2501)
      begin errors++; $display("FAIL drv_p_period got %0d want 2500+-1", r2 - r1); end
    if (pf < 0 || nr < 0 || nr - pf != 20)
      begin errors++; $display("FAIL dead_time got %0d want 20", nr - pf); end
    if (overlaps != 0) begin errors++; $display("FAIL overlap got %0d want 0", overlaps); end
    swiptAlive = 1'b0;
    @(negedge clk);
    if (drv_p !== 1'b0 || drv_n !== 1'b0)
      begin errors++; $display("FAIL alive_off got p=%b n=%b want 0 0", drv_p, drv_n); end
  endtask

  task automatic test_step();
    do_reset();
    pulse(1'b1, 1'b0);
    checks += 5;
    if (freq !== 20'd430571) begin errors++; $display("FAIL step_up_freq got %0d want 430571", freq); end
    if (step_ack !== 1'b1) begin errors++; $display("FAIL step_up_ack got %b want 1", step_ack); end
    @(negedge clk);
    if (step_ack !== 1'b0) begin errors++; $display("FAIL ack_width got %b want 0", step_ack); end
    pulse(1'b1, 1'b1);
    if (freq !== 20'd430571) begin errors++; $display("FAIL opt_freq got %0d want 430571", freq); end
    if (step_ack !== 1'b0) begin errors++; $display("FAIL opt_ack got %b want 0", step_ack); end
  endtask

  task automatic test_saturation();
    do_reset();
    freq_set_up_down = 1'b0;
    freq_ready = 1'b1;
    repeat (101) @(negedge clk);
    freq_ready = 1'b0;
    checks += 6;
    if (freq !== 20'd322123) begin errors++; $display("FAIL sat_lo_freq got %0d want 322123", freq); end
    if (freq_sat !== 1'b1) begin errors++; $display("FAIL sat_lo_flag got %b want 1", freq_sat); end
    if (step_ack !== 1'b1) begin errors++; $display("FAIL sat_lo_ack got %b want 1", step_ack); end
    pulse(1'b1, 1'b0);
`ifdef FREQ_STEP_ADAPT_EN
    if (freq !== 20'd322660) begin errors++; $display("FAIL sat_up_freq got %0d want 322660", freq); end
`else
    if (freq !== 20'd323197) begin errors++; $display("FAIL sat_up_freq got %0d want 323197", freq); end
`endif
    if (freq_sat !== 1'b0) begin errors++; $display("FAIL sat_up_flag got %b want 0", freq_sat); end
    if (step_ack !== 1'b1) begin errors++; $display("FAIL sat_up_ack got %b want 1", step_ack); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    freq_set_up_down = 1'b1;
    freq_ready = 1'b1;
    repeat (66) @(negedge clk);
    checks += 4;
    if (freq !== 20'd500381) begin errors++; $display("FAIL b2b_freq got %0d want 500381", freq); end
    data_start = 1'b1;
    @(negedge clk);
    data_start = 1'b0;
    freq_ready = 1'b0;
    if (freq !== 20'd429497) begin errors++; $display("FAIL restart_freq got %0d want 429497", freq); end
    if (step_ack !== 1'b0) begin errors++; $display("FAIL restart_ack got %b want 0", step_ack); end
    if (freq_sat !== 1'b0) begin errors++; $display("FAIL restart_sat got %b want 0", freq_sat); end
  endtask

  task automatic test_sequence();
    logic [19:0] exp [3];
`ifdef FREQ_STEP_ADAPT_EN
    exp = '{20'd430571, 20'd430034, 20'd429497};
`else
    exp = '{20'd430571, 20'd429497, 20'd428423};
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(i == 0, 1'b0);
      @(negedge clk);
      checks++;
      if (freq !== exp[i]) begin errors++; $display("FAIL seq_%0d got %0d want %0d", i, freq, exp[i]); end
    end
  endtask

  task automatic test_rst_mid_pulse();
    int found = 0;
    do_reset();
    swiptAlive = 1'b1;
    for (int c = 0; c < 200 && found == 0; c++) begin
      @(negedge clk);
      if (drv_n) found = 1;
    end
    checks += 3;
    if (found != 1) begin errors++; $display("FAIL first_n_on got %0d want 1", found); end
    rst = 1'b1;
    @(negedge clk);
    if (drv_p !== 1'b0 || drv_n !== 1'b0)
      begin errors++; $display("FAIL rst_mid got p=%b n=%b want 0 0", drv_p, drv_n); end
    rst = 1'b0;
    swiptAlive = 1'b0;
    @(negedge clk);
    if (overlaps != 0) begin errors++; $display("FAIL overlap_end got %0d want 0", overlaps); end
  endtask

  initial begin
    test_reset();
    test_drive();
    test_step();
    test_saturation();
    test_back_to_back();
    test_sequence();
    test_rst_mid_pulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
